// File: rtl/freq_gen_out.sv
// freq_gen_out
//   Programmable square-wave generator. A commanded frequency in Hz is turned
//   into a half-period in clock cycles by a restoring sequential divider
//   (CLK_HZ / (2*freq_in), truncated, clamped to at least 1). The output then
//   toggles every half_period cycles, giving an exact 50% duty square wave.
//
// Ports
//   clk          in   1       system clock, rising edge
//   reset        in   1       synchronous, active-high reset
//   freq_in      in   FREQ_W  requested frequency in Hz, 0 stops the output
//   load         in   1       1-cycle strobe, sampled only while busy==0
//   freq_out     out  1       generated square wave
//   busy         out  1       divider running, load ignored while high
//   active       out  1       freq_out is toggling
//   half_period  out  CNT_W   active half-period in clk cycles, 0 when stopped
//
// Configuration
//   FREQGEN_SYNC_UPDATE_EN  when defined, a new half-period computed while the
//   output is already running is held pending and only applied at the next
//   freq_out toggle (phase-continuous retune). When undefined, the new value
//   is applied at divide completion and the period counter restarts, which
//   can produce one runt or stretched half-cycle.

module freq_gen_out #(
  parameter int CLK_HZ = 50_000_000,
  parameter int FREQ_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              load,
  output logic              freq_out,
  output logic              busy,
  output logic              active,
  output logic [CNT_W-1:0]  half_period
);

  localparam int STEP_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    RUN
  } state_t;

  state_t state;

  logic [FREQ_W:0]   divisor;
  logic [CNT_W-1:0]  dvd;
  logic [FREQ_W:0]   rem;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  cnt;

`ifdef FREQGEN_SYNC_UPDATE_EN
  logic [CNT_W-1:0]  pend_hp;
  logic              pend;
`endif

  logic [FREQ_W+1:0] rem_sh;
  logic [FREQ_W:0]   rem_sub;
  logic              q_bit;
  logic [CNT_W-1:0]  quot;
  logic [CNT_W-1:0]  new_hp;
  logic              tick;

  // One restoring-division step. dvd holds the not-yet-consumed dividend bits
  // in its upper part and collects quotient bits from the bottom, so after
  // CNT_W steps it holds the full quotient. The remainder is always below the
  // divisor, so the subtraction can be done modulo 2^(FREQ_W+1).
  always_comb begin
    rem_sh  = {rem, dvd[CNT_W-1]};
    q_bit   = (rem_sh >= {1'b0, divisor});
    rem_sub = rem_sh[FREQ_W:0] - divisor;
    quot    = {dvd[CNT_W-2:0], q_bit};
    new_hp  = (quot == '0) ? CNT_W'(1) : quot;
    // >= so that a half-period shrunk below the current count restarts at once
    tick    = active && (cnt >= half_period - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      freq_out    <= 1'b0;
      busy        <= 1'b0;
      active      <= 1'b0;
      half_period <= '0;
      cnt         <= '0;
      divisor     <= '0;
      dvd         <= '0;
      rem         <= '0;
      step        <= '0;
`ifdef FREQGEN_SYNC_UPDATE_EN
      pend_hp     <= '0;
      pend        <= 1'b0;
`endif
    end else begin
      // The output generator keeps running in every state, including DIV.
      if (active) begin
        if (tick) begin
          cnt      <= '0;
          freq_out <= ~freq_out;
`ifdef FREQGEN_SYNC_UPDATE_EN
          if (pend) begin
            half_period <= pend_hp;
            pend        <= 1'b0;
          end
`endif
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (state == DIV) begin
        rem  <= (q_bit) ? rem_sub : rem_sh[FREQ_W:0];
        dvd  <= quot;
        step <= step + 1'b1;
        if (step == LAST_STEP) begin
          busy  <= 1'b0;
          state <= RUN;
`ifdef FREQGEN_SYNC_UPDATE_EN
          if (active) begin
            pend_hp <= new_hp;
            pend    <= 1'b1;
          end else begin
            half_period <= new_hp;
            cnt         <= '0;
            active      <= 1'b1;
          end
`else
          // Restart the count but hold the level; a toggle landing on this
          // same edge is suppressed.
          half_period <= new_hp;
          cnt         <= '0;
          freq_out    <= freq_out;
          active      <= 1'b1;
`endif
        end
      end else if (load) begin
        if (freq_in == '0) begin
          state       <= IDLE;
          active      <= 1'b0;
          freq_out    <= 1'b0;
          half_period <= '0;
          cnt         <= '0;
`ifdef FREQGEN_SYNC_UPDATE_EN
          pend        <= 1'b0;
`endif
        end else begin
          divisor <= {freq_in, 1'b0};
          dvd     <= CNT_W'(CLK_HZ);
          rem     <= '0;
          step    <= '0;
          busy    <= 1'b1;
          state   <= DIV;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_gen_out.sv
// tb_freq_gen_out
//   Self-checking bench for freq_gen_out. The DUT runs with a 1 MHz CLK_HZ so
//   that full output periods fit in a short run: 1000 Hz -> half-period 500,
//   4000 Hz -> 125, 65535 Hz -> 7. Expected half-periods come from an
//   arithmetic model, are queued when a load is accepted and popped when the
//   divider finishes.

module tb_freq_gen_out;

  localparam int CLK_HZ  = 1_000_000;
  localparam int FREQ_W  = 16;
  localparam int CNT_W   = 32;
  localparam int LOAD_AT = 400;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [FREQ_W-1:0] freq_in = '0;
  logic              load = 1'b0;
  logic              freq_out;
  logic              busy;
  logic              active;
  logic [CNT_W-1:0]  half_period;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  freq_gen_out #(
    .CLK_HZ(CLK_HZ),
    .FREQ_W(FREQ_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .freq_in    (freq_in),
    .load       (load),
    .freq_out   (freq_out),
    .busy       (busy),
    .active     (active),
    .half_period(half_period)
  );

  function automatic int model_hp(input int f);
    int q;
    q = CLK_HZ / (2 * f);
    if (q == 0) q = 1;
    return q;
  endfunction

  // Called on a falling edge; the following rising edge samples the load.
  task automatic pulse_load(input int f);
    freq_in = FREQ_W'(f);
    load    = 1'b1;
    if (busy === 1'b0 && f != 0) exp_q.push_back(model_hp(f));
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic measure_level(output int n);
    logic lvl;
    lvl = freq_out;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (freq_out === lvl && n < 5000);
    if (freq_out === lvl) n = -1;
  endtask

  task automatic pop_expected(output int e);
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty got no entry want one");
      e = -1;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (freq_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_freq_out got %0b want 0", freq_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    checks++;
    if (active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active got %0b want 0", active); end
    checks++;
    if (half_period !== '0) begin errors++; $display("[TB] FAIL reset_half_period got %0d want 0", half_period); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n, e;
    pulse_load(1000);
    count_busy(n);
    checks++;
    if (n != CNT_W) begin errors++; $display("[TB] FAIL basic_busy_len got %0d want %0d", n, CNT_W); end
    pop_expected(e);
    checks++;
    if (half_period !== CNT_W'(e)) begin errors++; $display("[TB] FAIL basic_half_period got %0d want %0d", half_period, e); end
    checks++;
    if (active !== 1'b1) begin errors++; $display("[TB] FAIL basic_active got %0b want 1", active); end
    measure_level(n);
    checks++;
    if (n != e || freq_out !== 1'b1) begin errors++; $display("[TB] FAIL basic_first_rise got %0d/%0b want %0d/1", n, freq_out, e); end
    measure_level(n);
    checks++;
    if (n != e) begin errors++; $display("[TB] FAIL basic_high_len got %0d want %0d", n, e); end
    measure_level(n);
    checks++;
    if (n != e) begin errors++; $display("[TB] FAIL basic_low_len got %0d want %0d", n, e); end
  endtask

  task automatic test_max_freq();
    int n, e;
    pulse_load(65535);
    count_busy(n);
    checks++;
    if (n != CNT_W) begin errors++; $display("[TB] FAIL max_busy_len got %0d want %0d", n, CNT_W); end
    pop_expected(e);
`ifdef FREQGEN_SYNC_UPDATE_EN
    checks++;
    if (half_period !== CNT_W'(500)) begin errors++; $display("[TB] FAIL max_pending_hp got %0d want 500", half_period); end
    measure_level(n);
`else
    measure_level(n);
`endif
    checks++;
    if (half_period !== CNT_W'(e)) begin errors++; $display("[TB] FAIL max_half_period got %0d want %0d", half_period, e); end
    measure_level(n);
    checks++;
    if (n != e) begin errors++; $display("[TB] FAIL max_level_a got %0d want %0d", n, e); end
    measure_level(n);
    checks++;
    if (n != e) begin errors++; $display("[TB] FAIL max_level_b got %0d want %0d", n, e); end
  endtask

  task automatic test_stop();
    int n, e, toggles;
    logic prev;
    pulse_load(1000);
    count_busy(n);
    pop_expected(e);
    checks++;
    if (half_period !== CNT_W'(e)) begin errors++; $display("[TB] FAIL stop_reload_hp got %0d want %0d", half_period, e); end
    measure_level(n);
    if (freq_out !== 1'b1) measure_level(n);
    repeat (100) @(negedge clk);
    pulse_load(0);
    checks++;
    if (freq_out !== 1'b0 || active !== 1'b0 || half_period !== '0 || busy !== 1'b0)
    begin
      errors++;
      $display("[TB] FAIL stop_outputs got out=%0b act=%0b hp=%0d busy=%0b want 0/0/0/0",
               freq_out, active, half_period, busy);
    end
    toggles = 0;
    prev = freq_out;
    repeat (3000) begin
      @(negedge clk);
      if (freq_out !== prev) toggles++;
      prev = freq_out;
    end
    checks++;
    if (toggles != 0) begin errors++; $display("[TB] FAIL stop_no_toggle got %0d want 0", toggles); end
  endtask

  task automatic test_busy_ignore();
    int n, e;
    pulse_load(1000);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 5) begin
        freq_in = FREQ_W'(2000);
        load    = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    checks++;
    if (n != CNT_W) begin errors++; $display("[TB] FAIL ignore_busy_len got %0d want %0d", n, CNT_W); end
    pop_expected(e);
    checks++;
    if (half_period !== CNT_W'(e)) begin errors++; $display("[TB] FAIL ignore_half_period got %0d want %0d", half_period, e); end

    pulse_load(4000);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL middiv_busy got %0b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    checks++;
    if (freq_out !== 1'b0 || busy !== 1'b0 || active !== 1'b0 || half_period !== '0)
    begin
      errors++;
      $display("[TB] FAIL middiv_reset got out=%0b busy=%0b act=%0b hp=%0d want 0/0/0/0",
               freq_out, busy, active, half_period);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (freq_out !== 1'b0 || busy !== 1'b0 || active !== 1'b0 || half_period !== '0)
    begin
      errors++;
      $display("[TB] FAIL middiv_no_update got out=%0b busy=%0b act=%0b hp=%0d want 0/0/0/0",
               freq_out, busy, active, half_period);
    end
  endtask

  task automatic test_retune();
    int n, e, a, b, first;
    pulse_load(1000);
    count_busy(n);
    pop_expected(e);
    measure_level(n);
    checks++;
    if (n != e) begin errors++; $display("[TB] FAIL retune_start_rise got %0d want %0d", n, e); end
    repeat (LOAD_AT) @(negedge clk);
    pulse_load(4000);
    count_busy(n);
    checks++;
    if (n != CNT_W) begin errors++; $display("[TB] FAIL retune_busy_len got %0d want %0d", n, CNT_W); end
    pop_expected(e);
`ifdef FREQGEN_SYNC_UPDATE_EN
    checks++;
    if (half_period !== CNT_W'(500)) begin errors++; $display("[TB] FAIL retune_pending_hp got %0d want 500", half_period); end
    first = 500 - (LOAD_AT + 1 + CNT_W);
`else
    first = e;
`endif
    measure_level(n);
    checks++;
    if (n != first) begin errors++; $display("[TB] FAIL retune_boundary got %0d want %0d", n, first); end
    checks++;
    if (half_period !== CNT_W'(e)) begin errors++; $display("[TB] FAIL retune_half_period got %0d want %0d", half_period, e); end
    measure_level(a);
    measure_level(b);
    checks++;
    if (a != e || b != e) begin errors++; $display("[TB] FAIL retune_levels got %0d/%0d want %0d/%0d", a, b, e, e); end
    checks++;
    if (a + b <= 0 || CLK_HZ / (a + b) != 4000) begin
      errors++;
      $display("[TB] FAIL retune_measured_freq got period %0d want %0d", a + b, CLK_HZ / 4000);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_freq();
    test_stop();
    test_busy_ignore();
    test_retune();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
